prefetch_queue: RTL and testbench

- Instruction prefetch stage directly upstream of `decode`.
- Issues 32-bit word reads on the core bus from a linear fetch address and buffers the returned bytes in a byte-wide ring queue.
- Presents the oldest 16 queued bytes as the `decode` instruction window.
- Retires bytes when decode reports how many it consumed, and restarts on flush (jump, fault, mode change).

---
 rtl/prefetch_queue.sv | 154 +++++++++++++++
 tb/tb_prefetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 32-bit words into a byte ring and presents a 16-byte decode window.
// Optional performance counters are enabled with `define PREFETCH_PERF_COUNTER_EN.
module prefetch_queue #(
  parameter int unsigned QUEUE_BYTES  = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic [31:0]      i_flush_address,
  output logic             bus_read_valid,
  input  logic             bus_read_ready,
  output logic [31:0]      bus_read_address,
  input  logic [31:0]      bus_read_data,
  output logic [15:0][7:0] o_instruction,
  output logic [4:0]       o_valid_bytes,
  input  logic             i_consume,
  input  logic [4:0]       i_bytes_consumed,
  output logic             o_consume_error
`ifdef PREFETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]      o_starve_cycles,
  output logic [15:0]      o_flush_count
`endif
);

  localparam int PTR_W = $clog2(QUEUE_BYTES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, DRAIN} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [QUEUE_BYTES];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [29:0]      fetch_word;
  logic [29:0]      next_word;
  logic [31:0]      req_addr;
  logic [1:0]       skip;
  logic             handshake, write_en, consume_ok, consume_bad, load_req;
  logic [2:0]       written;
  logic [4:0]       consumed;

  assign handshake   = bus_read_valid & bus_read_ready;
  assign write_en    = handshake && (state == REQUEST) && !i_flush;
  assign written     = write_en ? (3'd4 - {1'b0, skip}) : 3'd0;
  assign consume_ok  = i_consume && !i_flush && (i_bytes_consumed != 5'd0) &&
                       (i_bytes_consumed <= o_valid_bytes);
  assign consume_bad = i_consume && !i_flush && !consume_ok;
  assign consumed    = consume_ok ? i_bytes_consumed : 5'd0;
  assign count_next  = count + CNT_W'(written) - CNT_W'(consumed);
  // Word counter wraps naturally from 32'hFFFF_FFFC to 0.
  assign next_word   = bus_read_address[31:2] + 30'd1;
  assign req_addr    = {((state == REQUEST) ? next_word : fetch_word), 2'b00};

  assign o_valid_bytes = (count >= CNT_W'(16)) ? 5'd16 : 5'(count);

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < o_valid_bytes) o_instruction[i] = mem[rd_ptr + PTR_W'(i)];
      else                       o_instruction[i] = 8'h00;
    end
  end

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_flush && (count <= CNT_W'(QUEUE_BYTES - 4))) begin
          state_next = REQUEST;
          load_req   = 1'b1;
        end
      end
      REQUEST: begin
        // Back-to-back requests only when the post-write, post-consume space still fits a word.
        if (handshake) begin
          if (!i_flush && (count_next <= CNT_W'(QUEUE_BYTES - 4))) begin
            state_next = REQUEST;
            load_req   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (i_flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      fetch_word       <= RESET_VECTOR[31:2];
      skip             <= 2'd0;
      bus_read_valid   <= 1'b0;
      bus_read_address <= 32'd0;
      o_consume_error  <= 1'b0;
    end else begin
      state           <= state_next;
      o_consume_error <= consume_bad;
      bus_read_valid  <= (state_next != IDLE);
      if (load_req) bus_read_address <= req_addr;
      if (i_flush) begin
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fetch_word <= i_flush_address[31:2];
        skip       <= i_flush_address[1:0];
      end else begin
        count  <= count_next;
        rd_ptr <= rd_ptr + PTR_W'(consumed);
        if (write_en) begin
          wr_ptr     <= wr_ptr + PTR_W'(written);
          fetch_word <= next_word;
          skip       <= 2'd0;
        end
      end
    end
  end

  // Queue storage carries no reset; the count decides which bytes are meaningful.
  always_ff @(posedge clock) begin
    if (write_en) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= skip) mem[wr_ptr + PTR_W'(k) - PTR_W'(skip)] <= bus_read_data[8*k +: 8];
      end
    end
  end

`ifdef PREFETCH_PERF_COUNTER_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      o_starve_cycles <= 32'd0;
      o_flush_count   <= 16'd0;
    end else begin
      if ((o_valid_bytes < 5'd16) && (state != IDLE)) o_starve_cycles <= sat_inc32(o_starve_cycles);
      if (i_flush) o_flush_count <= o_flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a byte-queue reference model predicts the window,
// consume errors and fetch addresses; a negedge monitor compares against the DUT.
module tb_prefetch_queue;
  localparam int          QB = 32;
  localparam logic [31:0] RV = 32'hFFFF_FFF0;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             i_flush = 1'b0;
  logic [31:0]      i_flush_address = 32'd0;
  logic             bus_read_valid;
  logic             bus_read_ready = 1'b0;
  logic [31:0]      bus_read_address;
  logic [31:0]      bus_read_data = 32'd0;
  logic [15:0][7:0] o_instruction;
  logic [4:0]       o_valid_bytes;
  logic             i_consume = 1'b0;
  logic [4:0]       i_bytes_consumed = 5'd0;
  logic             o_consume_error;
`ifdef PREFETCH_PERF_COUNTER_EN
  logic [31:0]      o_starve_cycles;
  logic [15:0]      o_flush_count;
`endif

  always #5 clock = ~clock;

  prefetch_queue #(.QUEUE_BYTES(QB), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .i_flush(i_flush), .i_flush_address(i_flush_address),
    .bus_read_valid(bus_read_valid), .bus_read_ready(bus_read_ready),
    .bus_read_address(bus_read_address), .bus_read_data(bus_read_data),
    .o_instruction(o_instruction), .o_valid_bytes(o_valid_bytes),
    .i_consume(i_consume), .i_bytes_consumed(i_bytes_consumed), .o_consume_error(o_consume_error)
`ifdef PREFETCH_PERF_COUNTER_EN
    , .o_starve_cycles(o_starve_cycles), .o_flush_count(o_flush_count)
`endif
  );

  typedef struct packed {
    logic             is_reset;
    logic [4:0]       vb;
    logic [15:0][7:0] win;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  logic [31:0] m_fetch = RV;
  logic [1:0]  m_skip = 2'd0;
  bit          m_disc = 0;
  bit          quiet_edge = 1;
  logic        snap_valid = 1'b0;
  logic [31:0] snap_addr = 32'd0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  bit          prev_hs = 0;
  int          streak = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: advance on each rising edge using inputs and the last negedge snapshot.
  always @(posedge clock) begin
    exp_t e;
    int   vb;
    bit   hs;
    bit   err;
    if (reset) begin
      mq.delete();
      m_fetch = RV; m_skip = 2'd0; m_disc = 0; quiet_edge = 1;
      prev_valid = 1'b0; prev_hs = 0;
      e.is_reset = 1'b1; e.vb = 5'd0; e.win = '0; e.err = 1'b0;
      exp_q.push_back(e);
    end else begin
      vb  = (mq.size() > 16) ? 16 : mq.size();
      hs  = snap_valid && bus_read_ready;
      err = 0;
      if (snap_valid && !m_disc) chk("space_at_request", (mq.size() <= QB - 4), 1'b1);
      if (snap_valid && prev_valid && !prev_hs) chk("addr_held", snap_addr, prev_addr);
      if (i_flush) begin
        mq.delete();
        m_fetch = i_flush_address; m_skip = i_flush_address[1:0];
        m_disc = snap_valid && !hs;
        quiet_edge = 1;
      end else begin
        quiet_edge = 0;
        if (hs) begin
          if (m_disc) m_disc = 0;
          else begin
            chk("read_address", snap_addr, {m_fetch[31:2], 2'b00});
            for (int k = m_skip; k < 4; k++) mq.push_back(bus_read_data[8*k +: 8]);
            m_fetch = {m_fetch[31:2], 2'b00} + 32'd4;
            m_skip = 2'd0;
          end
        end
        if (i_consume) begin
          if (i_bytes_consumed >= 1 && int'(i_bytes_consumed) <= vb)
            repeat (int'(i_bytes_consumed)) void'(mq.pop_front());
          else err = 1;
        end
      end
      prev_valid = snap_valid; prev_addr = snap_addr; prev_hs = hs;
      e.is_reset = 1'b0;
      e.vb = 5'((mq.size() > 16) ? 16 : mq.size());
      for (int i = 0; i < 16; i++) e.win[i] = (i < int'(e.vb)) ? mq[i] : 8'h00;
      e.err = err;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid_bytes", o_valid_bytes, e.vb);
      chk("window", o_instruction, e.win);
      chk("consume_error", o_consume_error, e.err);
      if (e.is_reset) begin
        chk("reset_read_valid", bus_read_valid, 1'b0);
        chk("reset_read_address", bus_read_address, 32'd0);
        streak = 0;
      end else if (quiet_edge || bus_read_valid || mq.size() > QB - 4) begin
        streak = 0;
      end else begin
        streak++;
        chk("request_latency", (streak <= 1), 1'b1);
      end
    end
    snap_valid = bus_read_valid;
    snap_addr  = bus_read_address;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();                       // request held at the reset vector
    bus_read_data = 32'h4433_2211; bus_read_ready = 1'b1;
    step();
    bus_read_ready = 1'b0;
    repeat (2) step();
    bus_read_ready = 1'b1;                   // fill to full, crossing the address wrap
    repeat (16) begin
      bus_read_data = $urandom;
      step();
    end
    i_consume = 1'b1; i_bytes_consumed = 5'd5;
    step();
    i_consume = 1'b0;
    repeat (3) step();
    bus_read_ready = 1'b0;
    i_flush = 1'b1; i_flush_address = 32'h0000_1003;
    step();
    i_flush = 1'b0;
    repeat (3) step();
    bus_read_data = 32'hDDCC_BBAA; bus_read_ready = 1'b1;
    step(); step();
    bus_read_ready = 1'b0;
    step();
    i_consume = 1'b1; i_bytes_consumed = 5'd9;
    step();
    i_bytes_consumed = 5'd0;
    step();
    i_bytes_consumed = 5'd17;
    step();
    i_consume = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 499) == 0);
      bus_read_ready = ($urandom_range(0, 3) != 0);
      bus_read_data  = $urandom;
      i_flush        = ($urandom_range(0, 47) == 0);
      i_flush_address = $urandom;
      i_consume      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) i_bytes_consumed = 5'($urandom_range(0, 31));
      else i_bytes_consumed = 5'($urandom_range(1, (o_valid_bytes == 0) ? 1 : int'(o_valid_bytes)));
      step();
    end

    reset = 1'b0; i_flush = 1'b0; i_consume = 1'b0; bus_read_ready = 1'b0;
    repeat (3) step();
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
